truth_table_checker: RTL and testbench

Sequential hardware checker that exhaustively exercises a 3-input, 1-output combinational block on the logic trainer.
- Drives the block's A, B and C switches through all eight patterns, waiting a programmable settle time for each.
- Samples the block's F output and assembles the observed 8-entry truth table.
- Compares the observed table against an expected table latched at start, then reports pass/fail and a per-entry mismatch mask.

It sits opposite the device under test, replacing manual switch flipping and LED reading.

---
 rtl/truth_table_checker_if.sv | 25 ++
 rtl/truth_table_checker.sv | 128 ++++++++++++
 tb/tb_truth_table_checker.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// Control, result and device-drive signals between the truth-table checker and its surroundings.
// The checker uses the slave modport; the test fixture / device side uses master.
interface truth_table_checker_if;
  logic       start;
  logic [7:0] exp_table;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic       dut_f;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] observed;
  logic [7:0] mismatch;

  modport master (
    output start, exp_table, dut_f,
    input  dut_a, dut_b, dut_c, busy, done, pass, observed, mismatch
  );

  modport slave (
    input  start, exp_table, dut_f,
    output dut_a, dut_b, dut_c, busy, done, pass, observed, mismatch
  );
endinterface

// File: rtl/truth_table_checker.sv
// Walks a 3-input device through all 8 patterns, samples F after SETTLE_CYCLES+1 cycles each, compares to a latched table.
// Run latency 8*(SETTLE_CYCLES+1) cycles to the done pulse; no backpressure, start is only honoured in IDLE.
module truth_table_checker #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_checker_if.slave  tt
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_checker: SETTLE_CYCLES must lie in 1..255");
  end

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] obs_q, obs_d;
  logic [7:0] mm_q, mm_d;
  logic       pass_q, pass_d;
  logic [2:0] pat_q, pat_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       drive_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    mm_d    = mm_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        if (tt.start) begin
          exp_d   = tt.exp_table;
          obs_d   = 8'h00;
          mm_d    = 8'h00;
          pass_d  = 1'b0;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        obs_d[idx_q] = tt.dut_f;
        if (idx_q == 3'd7) begin
          // Verdict is formed from the table including the final sample, so it is valid in the done cycle.
          pass_d  = (obs_d == exp_q);
          mm_d    = obs_d ^ exp_q;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status and switch drive are decoded from next state so every output leaves a flop.
  always_comb begin
    drive_d = (state_d == SETTLE) || (state_d == SAMPLE);
    busy_d  = drive_d;
    done_d  = (state_d == DONE);
    pat_d   = drive_d ? idx_d : 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      exp_q   <= 8'h00;
      obs_q   <= 8'h00;
      mm_q    <= 8'h00;
      pass_q  <= 1'b0;
      pat_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tt.dut_a    = pat_q[2];
  assign tt.dut_b    = pat_q[1];
  assign tt.dut_c    = pat_q[0];
  assign tt.busy     = busy_q;
  assign tt.done     = done_q;
  assign tt.pass     = pass_q;
  assign tt.observed = obs_q;
  assign tt.mismatch = mm_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: device models drive dut_f, a queue holds expected run results.
module tb_truth_table_checker;

  typedef struct packed {
    logic [7:0] obs;
    logic [7:0] mm;
    logic       pas;
  } exp_t;

  logic clk;
  logic rst;
  int   mode;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  exp_t sb[$];

  truth_table_checker_if ifc ();
  truth_table_checker_if ifc2 ();

  truth_table_checker #(.SETTLE_CYCLES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .tt  (ifc)
  );

  truth_table_checker #(.SETTLE_CYCLES(1)) u_dut_fast (
    .clk (clk),
    .rst (rst),
    .tt  (ifc2)
  );

  function automatic logic fmodel(input int m, input logic a, input logic b, input logic c);
    case (m)
      0:       return c & (a | b);
      1:       return 1'b0;
      2:       return a;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] table_of(input int m);
    logic [7:0] t;
    logic [2:0] p;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p = 3'(i);
      t[i] = fmodel(m, p[2], p[1], p[0]);
    end
    return t;
  endfunction

  always_comb ifc.dut_f  = fmodel(mode, ifc.dut_a, ifc.dut_b, ifc.dut_c);
  always_comb ifc2.dut_f = fmodel(0, ifc2.dut_a, ifc2.dut_b, ifc2.dut_c);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;
  always @(negedge clk) if (ifc.done === 1'b1) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic logic [2:0] pat();
    return {ifc.dut_a, ifc.dut_b, ifc.dut_c};
  endfunction

  task automatic start_run(input logic [7:0] expv, input int m);
    exp_t e;
    logic [7:0] t;
    mode = m;
    t = table_of(m);
    e.obs = t;
    e.mm  = t ^ expv;
    e.pas = (t == expv);
    sb.push_back(e);
    ifc.exp_table = expv;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  // Called in the cycle after the accept edge; checks drive pattern and busy every cycle.
  task automatic wait_done(input bit disturb);
    int   k;
    exp_t e;
    k = 0;
    while (ifc.done !== 1'b1 && k < 200) begin
      chk("busy_during_run", ifc.busy, 1);
      chk("pattern", pat(), (k < 40) ? k / 5 : 0);
      if (disturb) begin
        ifc.start = (k % 3 == 0);
        if (k == 10) ifc.exp_table = 8'h00;
      end
      tick();
      k++;
    end
    ifc.start = 1'b0;
    chk("done_seen", ifc.done, 1);
    chk("run_length", k, 40);
    chk("busy_in_done", ifc.busy, 0);
    chk("pattern_in_done", pat(), 0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      chk("observed", ifc.observed, e.obs);
      chk("mismatch", ifc.mismatch, e.mm);
      chk("pass", ifc.pass, e.pas);
    end
  endtask

  initial begin
    int d0;
    int prev;
    int w;
    rst = 1'b1;
    mode = 0;
    ifc.start = 1'b0;
    ifc.exp_table = 8'h00;
    ifc2.start = 1'b0;
    ifc2.exp_table = 8'hA8;
    #3;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_pass", ifc.pass, 0);
    chk("rst_observed", ifc.observed, 0);
    chk("rst_mismatch", ifc.mismatch, 0);
    chk("rst_pattern", pat(), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_pattern", pat(), 0);

    // Good device, single run.
    start_run(8'hA8, 0);
    wait_done(1'b0);
    tick();
    chk("done_one_cycle", ifc.done, 0);

    // Stuck-at-0 device; verdict held after done.
    start_run(8'hA8, 1);
    wait_done(1'b0);
    repeat (6) tick();
    chk("hold_observed", ifc.observed, 8'h00);
    chk("hold_mismatch", ifc.mismatch, 8'hA8);
    chk("hold_pass", ifc.pass, 0);
    chk("hold_pattern_idle", pat(), 0);

    // F = A device.
    start_run(8'hA8, 2);
    wait_done(1'b0);
    tick();

    // Extra starts and exp_table change mid-run, start also raised in the done cycle.
    d0 = done_cnt;
    start_run(8'hA8, 0);
    wait_done(1'b1);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    chk("done_cycle_start_ignored", ifc.busy, 0);
    repeat (5) tick();
    chk("still_idle", ifc.busy, 0);
    chk("single_done", done_cnt - d0, 1);

    // Reset while pattern 3 is driven, with an always-1 device so the partial table is visible.
    mode = 3;
    ifc.exp_table = 8'hFF;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (16) tick();
    chk("pre_rst_pattern", pat(), 3);
    chk("pre_rst_partial", ifc.observed, 8'h07);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("arst_busy", ifc.busy, 0);
    chk("arst_pattern", pat(), 0);
    chk("arst_observed", ifc.observed, 0);
    chk("arst_done", ifc.done, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (45) tick();
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("idle_after_rst", ifc.busy, 0);
    start_run(8'hA8, 0);
    wait_done(1'b0);
    tick();

    // Fast instance, start held high: back-to-back runs every 18 cycles.
    ifc2.start = 1'b1;
    prev = 0;
    for (int r = 0; r < 4; r++) begin
      w = 0;
      while (ifc2.done !== 1'b1 && w < 60) begin
        tick();
        w++;
      end
      chk("fast_done_seen", ifc2.done, 1);
      chk("fast_pass", ifc2.pass, 1);
      chk("fast_observed", ifc2.observed, 8'hA8);
      chk("fast_mismatch", ifc2.mismatch, 8'h00);
      if (r > 0) chk("fast_period", cyc - prev, 18);
      prev = cyc;
      tick();
    end
    ifc2.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
